and_gate_tester: RTL and testbench

AND_GATE_TESTER -- requirements
Module: and_gate_tester

---
 rtl/and_gate_tester_pkg.sv | 25 ++
 rtl/and_gate_tester_settle_timer.sv | 46 ++++
 rtl/and_gate_tester.sv | 171 +++++++++++++++++
 tb/tb_and_gate_tester.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_tester_pkg.sv
// Shared definitions for the AND-gate tester.
//   state_e      : 2-bit FSM encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//   NUM_VECTORS  : number of input vectors applied per run
//   ERR_W        : width of the mismatch counter
//   SETTLE_W     : width of the settle down-counter
//   expected_out : golden response of the gate under test
package and_gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned SETTLE_W    = 4;

  // Golden two-input AND response.
  function automatic logic expected_out(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/and_gate_tester_settle_timer.sv
// settle_timer: 4-bit loadable down-counter that times how long a vector is
// held before sampling.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (clears the count)
//   load_i     : load load_val_i on the next edge (overrides counting)
//   load_val_i : settle length in cycles (1..15)
//   expired_o  : high during the last cycle of the settle window
module settle_timer
  import and_gate_tester_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  output logic                expired_o
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // Next count: load, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {SETTLE_W{1'b0}}) begin
      cnt_d = cnt_q - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {SETTLE_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one marks the final cycle of the window, so a load value of N
  // gives exactly N cycles.
  assign expired_o = (cnt_q == {{(SETTLE_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/and_gate_tester.sv
// and_gate_tester: exhaustively exercises an external two-input AND gate.
// Each of the four vectors is held for SETTLE_CYCLES cycles, then the gate
// output is sampled once and compared with a&b.
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : begin a run (honoured only when idle)
//   abort          : cancel a run in progress
//   dut_a, dut_b   : gate inputs, {dut_a,dut_b} = {k[0],k[1]}
//   dut_c          : gate output under test
//   busy           : high while driving/sampling
//   done           : one-cycle pulse at run completion
//   pass           : last completed run had no mismatches
//   err_count      : mismatches in the current/last run
//   fail_mask      : bit k set if vector k mismatched
// SETTLE_CYCLES must lie in 1..15.
module and_gate_tester
  import and_gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   dut_a,
  output logic                   dut_b,
  input  logic                   dut_c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [NUM_VECTORS-1:0] fail_mask
);

  localparam logic [1:0]       K_LAST  = 2'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NUM_VECTORS);

  state_e                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [NUM_VECTORS-1:0] mask_q, mask_d;
  logic                   pass_q, pass_d;
  logic                   dut_a_q, dut_a_d;
  logic                   dut_b_q, dut_b_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   load_s;
  logic                   expired_s;
  logic                   mismatch_s;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .load_val_i (SETTLE_W'(SETTLE_CYCLES)),
    .expired_o  (expired_s)
  );

  // Compare against the registered stimulus; dut_c only reaches registers.
  assign mismatch_s = dut_c ^ expected_out(dut_a_q, dut_b_q);

  // Next-state, counters and stimulus.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    dut_a_d = dut_a_q;
    dut_b_d = dut_b_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous abort.
        if (start) begin
          state_d = ST_DRIVE;
          k_d     = 2'd0;
          err_d   = {ERR_W{1'b0}};
          mask_d  = {NUM_VECTORS{1'b0}};
          pass_d  = 1'b0;
          load_s  = 1'b1;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
        end else if (expired_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        // An aborted sample leaves the result registers untouched.
        if (abort) begin
          state_d = ST_IDLE;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
        end else begin
          if (mismatch_s) begin
            mask_d[k_q] = 1'b1;
            err_d = (err_q != ERR_MAX) ? (err_q + ERR_W'(1)) : err_q;
          end else begin
            err_d = err_q;
          end
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
            pass_d  = (err_d == {ERR_W{1'b0}});
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
          end else begin
            state_d = ST_DRIVE;
            k_d     = k_q + 2'd1;
            load_s  = 1'b1;
            dut_a_d = k_d[0];
            dut_b_d = k_d[1];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      err_q   <= {ERR_W{1'b0}};
      mask_q  <= {NUM_VECTORS{1'b0}};
      pass_q  <= 1'b0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      dut_a_q <= dut_a_d;
      dut_b_q <= dut_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_and_gate_tester.sv
// Self-checking bench for and_gate_tester: a behavioural gate (truth table)
// feeds dut_c; each issued run pushes its expected result into a scoreboard
// queue which a monitor pops whenever done pulses.
module tb_and_gate_tester;

  localparam int S   = 2;
  localparam int LAT = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       dut_a, dut_b, dut_c, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [3:0] gate_tt;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  and_gate_tester #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_c     (dut_c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_mask (fail_mask)
  );

  // Gate under test: truth table indexed by {b,a}, which equals vector k.
  assign dut_c = gate_tt[{dut_b, dut_a}];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference: vector k is correct only if the gate gives (k==3).
  function automatic exp_t model(input logic [3:0] tt);
    exp_t e;
    e.mask = 4'd0;
    e.err  = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (tt[k] != (k == 3)) begin
        e.mask[k] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("pass", pass, e.pass);
        chk("err_count", err_count, e.err);
        chk("fail_mask", fail_mask, e.mask);
      end
    end
  end

  task automatic issue_start(input logic [3:0] tt, input logic ab);
    exp_t e;
    gate_tt = tt;
    @(negedge clk);
    start = 1'b1;
    abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    e     = model(tt);
    e.cyc = cyc + LAT;
    q.push_back(e);
    last_e = e;
  endtask

  task automatic wait_end(input bit noise);
    bit saw;
    saw = 1'b0;
    for (int i = 0; i < LAT + 10 && !saw; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
      start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    chk("run_completed", saw, 1);
  endtask

  task automatic check_hold();
    repeat (3) @(negedge clk);
    chk("hold_pass", pass, last_e.pass);
    chk("hold_err", err_count, last_e.err);
    chk("hold_mask", fail_mask, last_e.mask);
    chk("hold_idle_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dut_a"}, dut_a, 0);
    chk({tag, "_dut_b"}, dut_b, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_mask"}, fail_mask, 0);
  endtask

  task automatic full_run(input logic [3:0] tt, input logic ab, input bit noise);
    issue_start(tt, ab);
    wait_end(noise);
    check_hold();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    gate_tt = 4'b1000;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Good gate, first edge after reset release; then the fault gates.
    full_run(4'b1000, 1'b0, 1'b0);
    full_run(4'b0000, 1'b0, 1'b0);
    full_run(4'b1111, 1'b0, 1'b0);
    full_run(4'b1110, 1'b0, 1'b0);
    // abort together with start in idle: run still starts.
    full_run(4'b1000, 1'b1, 1'b0);

    // abort while idle has no effect.
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_hold();

    // Abort during vector k=2 ({a,b}=01).
    issue_start(4'b1000, 1'b0);
    void'(q.pop_back());
    found = 1'b0;
    for (int i = 0; i < LAT + 4 && !found; i++) begin
      @(negedge clk);
      if (busy && !dut_a && dut_b) found = 1'b1;
    end
    chk("reach_k2", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_a", dut_a, 0);
    chk("abort_dut_b", dut_b, 0);
    chk("abort_mask", fail_mask, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_count, 0);
    repeat (LAT + 4) @(negedge clk);
    chk("abort_no_done_busy", busy, 0);
    full_run(4'b1000, 1'b0, 1'b1);

    // Mid-run reset pulse of one time unit, then a fresh run.
    issue_start(4'b1111, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check_all_zero("post_reset");
    full_run(4'b1000, 1'b0, 1'b1);

    // Randomized gates, start noise and start+abort collisions.
    for (int r = 0; r < 12; r++) begin
      full_run(4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
